lift_call_scheduler: RTL and testbench
======================================

// Module: lift_call_scheduler
// PURPOSE
//  Upstream of LiftFSM. Registers the six hall-call buttons (1U,2U,3U,2D,3D,4D), holds them as pending
//  calls and presents one at a time to LiftFSM as a 3-bit call code with a valid/ack handshake.
//  Uses a sweep (elevator) order based on the current lift floor. Drives the hall-button lamps.
// PARAMETERS
//  SYNC_STAGES  2   synchroniser flops on each btn input (min 2)
//  ACK_TIMEOUT  64  cycles in ISSUE without req_ack before the grant is withdrawn (min 2)
// PORTS
//  clk        in   1  system clock, rising edge
//  rst        in   1  asynchronous reset, active-high
//  btn        in   6  raw hall buttons, level: [0]1U [1]2U [2]3U [3]2D [4]3D [5]4D
//  cur_floor  in   2  lift position from LiftFSM: 01=F1 10=F2 11=F3 00=F4
//  req_ack    in   1  LiftFSM accepted req_code (1-cycle pulse)
//  req_code   out  3  [2] 0=UP 1=DOWN, [1:0] floor as cur_floor; 000 when req_valid=0
//  req_valid  out  1  req_code is valid; code held stable until ack or timeout
//  lamp       out  6  pending calls, same bit map as btn
//  timeout    out  1  1-cycle pulse when a grant is withdrawn by timeout
// BEHAVIOUR
//  Reset: all outputs 0. pending=0. sweep=UP. FSM=IDLE. Sync and edge flops=0. Counter=0.
//  Button path: SYNC_STAGES flops, then a rising-edge detect. An edge sets pending[i].
//   Latency: btn rises -> lamp[i]=1 after SYNC_STAGES+1 clocks.
//   A held button or a re-press of a pending call has no further effect.
//  lamp = pending (registered, no extra delay).
//  Floor rank: F1=1..F4=4. Codes: 1U=001 2U=010 3U=011 2D=110 3D=111 4D=100.
//  Arbitration (combinational over pending, cur_floor, sweep). Pick the first pending call in this order:
//   sweep=UP:   UP calls rank>=cur ascending; then DOWN calls 4D,3D,2D; then UP calls rank<cur ascending
//   sweep=DOWN: DOWN calls rank<=cur descending; then UP calls 1U,2U,3U; then DOWN calls rank>cur descending
//  FSM states: IDLE, ISSUE, HOLDOFF.
//   IDLE: if pending!=0 -> ISSUE on the next edge. Latch req_code=winner, req_valid=1, sweep=winner[2],
//     counter=0. This gives 1 cycle from lamp set to req_valid.
//   ISSUE: req_code/req_valid frozen; changes to pending or cur_floor do not re-arbitrate.
//     req_ack=1 -> clear pending[granted], req_valid=0, req_code=000, -> HOLDOFF.
//     else counter==ACK_TIMEOUT-1 -> req_valid=0, req_code=000, timeout=1 for 1 cycle, pending kept,
//     -> HOLDOFF.
//     else counter++.
//   HOLDOFF: one cycle, req_valid=0, -> IDLE. This guarantees at least 1 low cycle between grants.
//  req_ack outside ISSUE: ignored.
//  Set/clear collision: a button edge on the granted bit in the same cycle as req_ack -> set wins;
//   the bit stays pending.
//  Multiple simultaneous edges: all set in the same cycle.
//  Counter width: $clog2(ACK_TIMEOUT). It saturates and never wraps.
//  rst mid-ISSUE: immediate clear of all state. Pending calls are lost; the user must press again.
// TESTING
//  1 Reset: rst=1 for 3 clk -> req_valid=0, req_code=000, lamp=000000, timeout=0; hold after release.
//  2 Single call: cur_floor=01, pulse btn[1] (2U) -> lamp=000010 at +3 clk, req_valid=1 with
//    req_code=010 one clk later; req_ack -> lamp=0, req_valid=0 for >=1 clk.
//  3 Sweep order: cur_floor=10, sweep=UP, press 1U,3U,4D together -> grants 011, then 100, then 001
//    (ack each); sweep=DOWN after 100.
//  4 Collision: in ISSUE for 3U, an edge on btn[2] lands in the ack cycle -> lamp[2] stays 1,
//    re-granted 011 after HOLDOFF.
//  5 Timeout: ACK_TIMEOUT=8, no ack -> req_valid falls after 8 clk in ISSUE, timeout pulse 1 clk,
//    same code re-issued 2 clk later.
//  6 Reset mid-ISSUE with lamp=101010 -> all outputs 0 asynchronously, no grant after release
//    until a new press.

Source files
------------

// File: rtl/lift_call_if.sv
// Hall-call request bundle between the call scheduler and LiftFSM.
// Latency: none, wires only.
// Backpressure: req_valid is held until req_ack or a scheduler timeout.
interface lift_call_if;
    logic [5:0] btn;
    logic [1:0] cur_floor;
    logic       req_ack;
    logic [2:0] req_code;
    logic       req_valid;
    logic [5:0] lamp;
    logic       timeout;

    // master: the scheduler, which owns the request
    modport master (
        input  btn, cur_floor, req_ack,
        output req_code, req_valid, lamp, timeout
    );

    // slave: the button panel and LiftFSM side
    modport slave (
        output btn, cur_floor, req_ack,
        input  req_code, req_valid, lamp, timeout
    );
endinterface

// File: rtl/lift_call_scheduler.sv
// Latches hall calls and grants them one at a time to LiftFSM in sweep order.
// Latency: btn to lamp is SYNC_STAGES+1 clocks; lamp to req_valid is 1 clock.
// Backpressure: the grant is held until req_ack, or withdrawn after ACK_TIMEOUT cycles.
module lift_call_scheduler #(
    parameter int SYNC_STAGES = 2,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic           clk,
    input  logic           rst,
    lift_call_if.master    bus
);
    localparam int CW = $clog2(ACK_TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, HOLDOFF} state_t;

    state_t                             state, state_n;
    logic [SYNC_STAGES-1:0][5:0]        sync_q;
    logic [5:0]                         prev_q;
    logic [5:0]                         edges;
    logic [5:0]                         pending, pending_n, clr;
    logic                               sweep, sweep_n;
    logic [CW-1:0]                      cnt, cnt_n;
    logic [2:0]                         grant, grant_n;
    logic [2:0]                         code, code_n;
    logic                               valid, valid_n;
    logic                               tout, tout_n;
    logic [2:0]                         win_idx;
    logic                               win_found;
    int                                 cur_rank;

    // Bit index of a call -> 3-bit call code (direction, floor)
    function automatic logic [2:0] code_of(input logic [2:0] idx);
        case (idx)
            3'd0:    code_of = 3'b001;
            3'd1:    code_of = 3'b010;
            3'd2:    code_of = 3'b011;
            3'd3:    code_of = 3'b110;
            3'd4:    code_of = 3'b111;
            3'd5:    code_of = 3'b100;
            default: code_of = 3'b000;
        endcase
    endfunction

    // A call is registered once, on the first cycle its synchronised button is seen high
    assign edges = sync_q[SYNC_STAGES-1] & ~prev_q;

    // Button synchroniser chain plus the delayed copy for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.btn};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Sweep arbitration; UP call at rank r is bit r-1, DOWN call at rank r is bit r+1
    always_comb begin
        win_found = 1'b0;
        win_idx   = 3'd0;
        cur_rank  = (bus.cur_floor == 2'b00) ? 4 : int'(bus.cur_floor);
        if (!sweep) begin
            for (int r = 1; r <= 3; r++)
                if (!win_found && pending[r-1] && r >= cur_rank) begin
                    win_found = 1'b1; win_idx = 3'(r - 1);
                end
            for (int r = 4; r >= 2; r--)
                if (!win_found && pending[r+1]) begin
                    win_found = 1'b1; win_idx = 3'(r + 1);
                end
            for (int r = 1; r <= 3; r++)
                if (!win_found && pending[r-1] && r < cur_rank) begin
                    win_found = 1'b1; win_idx = 3'(r - 1);
                end
        end else begin
            for (int r = 4; r >= 2; r--)
                if (!win_found && pending[r+1] && r <= cur_rank) begin
                    win_found = 1'b1; win_idx = 3'(r + 1);
                end
            for (int r = 1; r <= 3; r++)
                if (!win_found && pending[r-1]) begin
                    win_found = 1'b1; win_idx = 3'(r - 1);
                end
            for (int r = 4; r >= 2; r--)
                if (!win_found && pending[r+1] && r > cur_rank) begin
                    win_found = 1'b1; win_idx = 3'(r + 1);
                end
        end
    end

    // Grant FSM next-state and registered-output logic
    always_comb begin
        state_n = state;
        code_n  = code;
        valid_n = valid;
        tout_n  = 1'b0;
        sweep_n = sweep;
        cnt_n   = cnt;
        grant_n = grant;
        clr     = '0;
        case (state)
            IDLE: begin
                if (win_found) begin
                    state_n = ISSUE;
                    code_n  = code_of(win_idx);
                    valid_n = 1'b1;
                    sweep_n = code_of(win_idx) >> 2 != 3'd0;
                    cnt_n   = '0;
                    grant_n = win_idx;
                end
            end
            ISSUE: begin
                if (bus.req_ack) begin
                    clr     = 6'b000001 << grant;
                    valid_n = 1'b0;
                    code_n  = 3'b000;
                    state_n = HOLDOFF;
                end else if (cnt == CW'(ACK_TIMEOUT - 1)) begin
                    valid_n = 1'b0;
                    code_n  = 3'b000;
                    tout_n  = 1'b1;
                    state_n = HOLDOFF;
                end else if (cnt != '1) begin
                    cnt_n = cnt + 1'b1;
                end
            end
            HOLDOFF: begin
                valid_n = 1'b0;
                code_n  = 3'b000;
                state_n = IDLE;
            end
            default: begin
                valid_n = 1'b0;
                code_n  = 3'b000;
                state_n = IDLE;
            end
        endcase
        // A new press of the granted call in the ack cycle must survive the clear
        pending_n = (pending & ~clr) | edges;
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            pending <= '0;
            sweep   <= 1'b0;
            cnt     <= '0;
            grant   <= '0;
            code    <= '0;
            valid   <= 1'b0;
            tout    <= 1'b0;
        end else begin
            state   <= state_n;
            pending <= pending_n;
            sweep   <= sweep_n;
            cnt     <= cnt_n;
            grant   <= grant_n;
            code    <= code_n;
            valid   <= valid_n;
            tout    <= tout_n;
        end
    end

    assign bus.req_code  = code;
    assign bus.req_valid = valid;
    assign bus.lamp      = pending;
    assign bus.timeout   = tout;
endmodule

// File: tb/tb_lift_call_scheduler.sv
// Randomized bench for lift_call_scheduler with a sweep-order reference model.
// Latency: checks grant latency, holdoff gap and timeout length in cycles.
// Backpressure: acks after a random delay or lets the grant time out.
module tb_lift_call_scheduler;
    localparam int SS = 2;
    localparam int AT = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lift_call_if bus();

    lift_call_scheduler #(.SYNC_STAGES(SS), .ACK_TIMEOUT(AT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         checks = 0;
    int         errors = 0;
    bit [5:0]   m_pend = '0;
    bit         m_sweep = 1'b0;
    int         cur_w;
    logic [2:0] exp_q[$];
    bit         prev_valid = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] code_of(input int i);
        logic [2:0] t [6] = '{3'b001, 3'b010, 3'b011, 3'b110, 3'b111, 3'b100};
        return t[i];
    endfunction

    // Lowest key wins: the group of the sweep rule times 10 plus the order inside the group
    function automatic int pick(input bit [5:0] p, input logic [1:0] f, input bit sw);
        int cur, best, bestkey, key, r;
        bit dn;
        cur = (f == 2'b00) ? 4 : int'(f);
        best = -1;
        bestkey = 1000;
        for (int i = 0; i < 6; i++) begin
            if (!p[i]) continue;
            dn = (i >= 3);
            r  = dn ? i - 1 : i + 1;
            if (!sw) key = (!dn && r >= cur) ? r : (dn ? 10 + (4 - r) : 20 + r);
            else     key = (dn && r <= cur) ? (4 - r) : (!dn ? 10 + r : 20 + (4 - r));
            if (key < bestkey) begin
                bestkey = key;
                best = i;
            end
        end
        return best;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input bit [5:0] m);
        bus.btn = m;
        tick();
        bus.btn = '0;
    endtask

    // Scoreboard monitor: every new grant is compared with the oldest expectation
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (bus.req_valid && !prev_valid) begin
                if (exp_q.size() == 0) check("unexpected_grant", bus.req_code, 0);
                else check("grant_code", bus.req_code, exp_q.pop_front());
            end
            if (!bus.req_valid) check("idle_code_zero", bus.req_code, 0);
            prev_valid = bus.req_valid;
        end
    end

    // Push the model's next winner and wait for the DUT to raise req_valid
    task automatic issue_next(input int gap);
        int n;
        cur_w = pick(m_pend, bus.cur_floor, m_sweep);
        exp_q.push_back(code_of(cur_w));
        m_sweep = (cur_w >= 3);
        n = 0;
        while (!bus.req_valid && n < 12) begin
            tick();
            n++;
        end
        check("grant_gap", n, gap);
        if (!bus.req_valid) begin
            $display("FAIL grant_missing: no req_valid for code %0h", code_of(cur_w));
            $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
            $fatal(1, "grant missing");
        end
    endtask

    task automatic start(input bit [5:0] mask);
        press(mask);
        m_pend |= mask;
        tick();
        tick();
        check("lamp_set", bus.lamp, m_pend);
        issue_next(1);
    endtask

    // Handle the current grant by ack (returns in HOLDOFF) or timeout (returns in IDLE)
    task automatic serve(input bit to_mode);
        int n, d;
        if (to_mode) begin
            n = 0;
            while (bus.req_valid && n < 20) begin
                tick();
                n++;
            end
            check("timeout_len", n, AT);
            check("timeout_pulse", bus.timeout, 1);
            check("timeout_lamp_kept", bus.lamp, m_pend);
            tick();
            check("timeout_pulse_end", bus.timeout, 0);
        end else begin
            d = $urandom_range(0, AT - 2);
            repeat (d) tick();
            bus.req_ack = 1'b1;
            tick();
            bus.req_ack = 1'b0;
            m_pend[cur_w] = 1'b0;
            check("ack_lamp", bus.lamp, m_pend);
            check("ack_valid_low", bus.req_valid, 0);
            check("ack_no_timeout", bus.timeout, 0);
        end
    endtask

    task automatic drain(input bit force_to, input int pct);
        int  tos = 0;
        bit  tm;
        for (int k = 0; k < 40; k++) begin
            tm = (force_to && k == 0) || (tos < 2 && $urandom_range(0, 99) < pct);
            serve(tm);
            if (tm) tos++;
            if ($urandom_range(0, 1) == 1) bus.cur_floor = 2'($urandom_range(0, 3));
            if (m_pend == 0) break;
            issue_next(tm ? 1 : 2);
        end
        check("drained_lamp", bus.lamp, 0);
    endtask

    initial begin
        bus.btn = '0;
        bus.req_ack = 1'b0;
        bus.cur_floor = 2'b01;

        // Reset state, held and after release
        repeat (3) tick();
        check("rst_valid", bus.req_valid, 0);
        check("rst_code", bus.req_code, 0);
        check("rst_lamp", bus.lamp, 0);
        check("rst_timeout", bus.timeout, 0);
        rst = 1'b0;
        repeat (3) tick();
        check("post_rst_valid", bus.req_valid, 0);
        check("post_rst_lamp", bus.lamp, 0);

        // Single call 2U from F1
        bus.cur_floor = 2'b01;
        start(6'b000010);
        drain(1'b0, 0);

        // Sweep order from F2 going UP: 1U, 3U, 4D pressed together
        bus.cur_floor = 2'b10;
        start(6'b100101);
        drain(1'b0, 0);

        // Collision: re-press of 3U lands in the ack cycle
        bus.cur_floor = 2'b01;
        start(6'b000100);
        bus.btn = 6'b000100;
        tick();
        bus.btn = '0;
        tick();
        bus.req_ack = 1'b1;
        tick();
        bus.req_ack = 1'b0;
        check("collision_lamp", bus.lamp, m_pend);
        issue_next(2);
        drain(1'b0, 0);

        // Forced timeout on the first grant
        bus.cur_floor = 2'($urandom_range(0, 3));
        start(6'b001000);
        drain(1'b1, 0);

        // Randomized rounds
        for (int i = 0; i < 30; i++) begin
            bus.cur_floor = 2'($urandom_range(0, 3));
            start(6'($urandom_range(1, 63)));
            drain(1'b0, 25);
        end

        // Reset while a grant is outstanding
        bus.cur_floor = 2'b10;
        start(6'b101010);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", bus.req_valid, 0);
        check("arst_code", bus.req_code, 0);
        check("arst_lamp", bus.lamp, 0);
        check("arst_timeout", bus.timeout, 0);
        m_pend = '0;
        m_sweep = 1'b0;
        exp_q.delete();
        tick();
        tick();
        rst = 1'b0;
        repeat (10) tick();
        check("after_arst_valid", bus.req_valid, 0);
        check("after_arst_lamp", bus.lamp, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
